// File: rtl/rca_pkg.sv
// rca_pkg: shared types and helpers for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

    // Control payload that travels with each beat through the stage registers.
    typedef struct packed {
        logic vld;    // stage holds a live beat
        logic carry;  // carry out of the chunk this stage completed
    } rca_ctrl_t;

    // Number of ripple stages for a given total width and chunk size.
    function automatic int rca_stage_count(input int width, input int chunk);
        if (chunk < 1) begin
            return 1;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/rca_stage.sv
// rca_stage: purely combinational CHUNK-bit ripple of full adders.
// Also exposes the carry into the chunk MSB so the final stage can form signed overflow.
module rca_stage
    import rca_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    // Ripple the carry bit by bit; the loop variable keeps the chain acyclic.
    always_comb begin
        logic carry;
        carry    = cin;
        sum      = '0;
        c_msb_in = cin;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb_in = carry;
            sum[i]   = a[i] ^ b[i] ^ carry;
            carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/rca_pipe_adder.sv
// rca_pipe_adder: WIDTH-bit add/sub split into WIDTH/CHUNK registered ripple stages
// with valid/ready flow control on both sides and a signed-overflow flag.
// Optional macro RCA_PIPE_SAT_EN: saturate out_sum to the signed limit on overflow.
module rca_pipe_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = rca_stage_count(WIDTH, CHUNK);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_cfg_check
        $error("rca_pipe_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] vld_vec;
    logic [STAGES-1:0] rdy;

    // Subtraction is A + ~B + ~borrow; the mode is consumed here so each beat carries it implicitly.
    always_comb begin
        b_eff   = in_sub ? ~in_b : in_b;
        cin_eff = in_sub ? ~in_cin : in_cin;
    end

    // A stage may advance unless it and every stage after it are full and the sink stalls.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_rdy
        assign rdy[gi] = out_ready || !(&vld_vec[STAGES-1:gi]);
    end

    assign in_ready = rdy[0];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * CHUNK;                 // first bit this stage sums
        localparam int RB = WIDTH - (gi + 1) * CHUNK;   // B' bits still to be consumed downstream

        // acc word: completed sum bits below LO+CHUNK, untouched A bits above.
        logic [WIDTH-1:0]    acc_src;
        logic [RB+CHUNK-1:0] b_src;
        logic                c_src;
        logic                v_src;
        logic [CHUNK-1:0]    s_chunk;
        logic                c_out;
        logic                c_msb;
        logic                load;
        rca_ctrl_t           ctrl_d;
        rca_ctrl_t           ctrl_q;
        logic [WIDTH-1:0]    acc_d;
        logic [WIDTH-1:0]    acc_q;

        if (gi == 0) begin : g_src
            assign acc_src = in_a;
            assign b_src   = b_eff;
            assign c_src   = cin_eff;
            assign v_src   = in_valid;
        end else begin : g_src
            assign acc_src = g_stage[gi-1].acc_q;
            assign b_src   = g_stage[gi-1].g_brem.b_rem_q;
            assign c_src   = g_stage[gi-1].ctrl_q.carry;
            assign v_src   = g_stage[gi-1].ctrl_q.vld;
        end

        rca_stage #(.CHUNK(CHUNK)) u_stage (
            .a        (acc_src[LO +: CHUNK]),
            .b        (b_src[CHUNK-1:0]),
            .cin      (c_src),
            .sum      (s_chunk),
            .cout     (c_out),
            .c_msb_in (c_msb)
        );

        assign vld_vec[gi] = ctrl_q.vld;
        assign load        = rdy[gi] && v_src;

        // Take the upstream beat (or a bubble) when allowed to advance; otherwise hold.
        always_comb begin
            ctrl_d = ctrl_q;
            acc_d  = acc_q;
            if (rdy[gi]) begin
                ctrl_d.vld = v_src;
            end
            if (load) begin
                ctrl_d.carry       = c_out;
                acc_d              = acc_src;
                acc_d[LO +: CHUNK] = s_chunk;
`ifdef RCA_PIPE_SAT_EN
                // Positive overflow shows a negative sign bit, negative overflow a positive one.
                if (gi == STAGES - 1 && (c_msb ^ c_out)) begin
                    acc_d = s_chunk[CHUNK-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                             : {1'b1, {(WIDTH-1){1'b0}}};
                end
`endif
            end
        end

        // Stage register; reset flushes any beat in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_q <= '0;
                acc_q  <= '0;
            end else begin
                ctrl_q <= ctrl_d;
                acc_q  <= acc_d;
            end
        end

        if (RB > 0) begin : g_brem
            logic [RB-1:0] b_rem_d;
            logic [RB-1:0] b_rem_q;

            // Forward the B' bits not yet summed, shifted so the next chunk sits at bit 0.
            always_comb begin
                b_rem_d = b_rem_q;
                if (load) begin
                    b_rem_d = b_src[RB+CHUNK-1:CHUNK];
                end
            end

            // Remaining-operand register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_rem_q <= '0;
                end else begin
                    b_rem_q <= b_rem_d;
                end
            end
        end

        if (gi == STAGES - 1) begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Signed overflow: carry into the MSB disagrees with carry out of it.
            always_comb begin
                ovf_d = ovf_q;
                if (load) begin
                    ovf_d = c_msb ^ c_out;
                end
            end

            // Overflow flag register, aligned with the final sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end else begin : g_mid
            // Only the top chunk's MSB carry matters for overflow.
            logic c_msb_unused;
            assign c_msb_unused = c_msb;
        end
    end

    assign out_valid = g_stage[STAGES-1].ctrl_q.vld;
    assign out_sum   = g_stage[STAGES-1].acc_q;
    assign out_cout  = g_stage[STAGES-1].ctrl_q.carry;
    assign out_ovf   = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// tb_rca_pipe_adder: directed and randomized checks of rca_pipe_adder (WIDTH=32, CHUNK=8).
module tb_rca_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    rca_pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then reduce to the 32-bit view.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        longint unsigned ua, ub, uc, ut;
        longint          sa, sb, sc, st;
        res_t            r;
        ua = longint'(a);
        ub = longint'(b);
        uc = longint'(cin);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'(cin);
        ut = sub ? (64'd4294967296 + ua - ub - uc) : (ua + ub + uc);
        st = sub ? (sa - sb - sc) : (sa + sb + sc);
        r.sum  = ut[31:0];
        r.cout = ut[32];
        r.ovf  = (st > SMAX) || (st < SMIN);
`ifdef RCA_PIPE_SAT_EN
        if (st > SMAX) r.sum = 32'h7FFF_FFFF;
        else if (st < SMIN) r.sum = 32'h8000_0000;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One isolated beat: checks acceptance, exact latency, result and drain.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input res_t exp);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            @(negedge clk);
            chk({tag, "_lat_valid"}, out_valid, (k == STAGES - 1));
            if (k < STAGES - 1) @(posedge clk);
        end
        chk({tag, "_result"}, {out_ovf, out_cout, out_sum}, exp);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_drained"}, out_valid, 0);
        @(posedge clk); #1;
        $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                 tag, a, b, cin, sub, exp.sum, exp.cout, exp.ovf);
    endtask

    // Random stream of n beats; toggle=1 alternates out_ready, toggle=0 holds it high.
    task automatic run_stream(input string tag, input int n, input bit toggle);
        res_t        exp_q[$];
        res_t        e;
        logic [31:0] a, b;
        logic        cin, sub;
        int          sent, got, it;
        logic        prev_stall;
        logic [33:0] prev_out;
        sent = 0; got = 0; it = 0; prev_stall = 1'b0; prev_out = '0;
        a = $urandom; b = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        while (got < n && it < n * 4 + 40) begin
            out_ready = toggle ? (it % 2 == 1) : 1'b1;
            in_valid  = (sent < n);
            in_a = a; in_b = b; in_cin = cin; in_sub = sub;
            @(negedge clk);
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, out_valid, 1);
                chk({tag, "_stall_data"}, {out_ovf, out_cout, out_sum}, prev_out);
            end
            chk({tag, "_in_ready"}, in_ready, (out_ready || (sent - got) < STAGES));
            if (!toggle)
                chk({tag, "_tput_valid"}, out_valid, (it >= STAGES && it <= n + STAGES - 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_spurious"}, out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_result"}, {out_ovf, out_cout, out_sum}, e);
                    $display("txn %s out #%0d sum=%h cout=%0d ovf=%0d", tag, got, out_sum, out_cout, out_ovf);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
                a = $urandom; b = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_ovf, out_cout, out_sum};
            @(posedge clk); #1;
            it++;
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, got, n);
    endtask

    initial begin
        res_t r3;
        res_t rq[$];
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {out_ovf, out_cout, out_sum}, 0);
        chk("rst_in_ready", in_ready, 1);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        send_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        send_one("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
`ifdef RCA_PIPE_SAT_EN
        r3 = {1'b1, 1'b0, 32'h7FFF_FFFF};
`else
        r3 = {1'b1, 1'b0, 32'h8000_0000};
`endif
        send_one("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r3);
        send_one("sub_borrow", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFF});

        // Random streams
        run_stream("stall16", 16, 1'b1);
        run_stream("tput100", 100, 1'b0);

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a = $urandom; in_b = $urandom; in_cin = 1'b0; in_sub = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            chk("flush_in_ready", in_ready, 1);
            rq.push_back(model(in_a, in_b, in_cin, in_sub));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("flush_pre_valid", out_valid, 1);
        chk("flush_pre_data", {out_ovf, out_cout, out_sum}, rq[0]);
        #2 rst_n = 1'b0;
        #1;
        chk("flush_async_valid", out_valid, 0);
        chk("flush_async_sum", out_sum, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("flush_no_stale", out_valid, 0);
            @(posedge clk); #1;
        end
        $display("txn flush: 3 beats discarded by reset");
        send_one("post_rst", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0,
                 model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
